// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the two-master RAM arbiter
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_e;

  localparam logic [31:0] RAM_BASE_DEFAULT = 32'h0002_0000;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with a registered last-grant pointer
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_in,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  owner_e last_q, last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (!rst_in) begin
      // m0 wins unless it was the last one served and m1 is also waiting
      if (req[0] && (!req[1] || last_q == M1)) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
      if (gnt[0]) begin
        last_d = M0;
      end else if (gnt[1]) begin
        last_d = M1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      last_q <= M1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - shares one synchronous RAM port between two masters, one access per cycle
// Optional MEM_ARB_ADDR_CHECK_EN: out-of-window or misaligned requests are answered with err.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned RAM_AW   = 15,
  parameter logic [31:0] RAM_BASE = RAM_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [3:0]        m0_byteen,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [3:0]        m1_byteen,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [3:0]        ram_byteen,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  logic [1:0]  arb_req;
  logic [1:0]  arb_gnt;
  logic        sel_m1;
  logic        any_gnt;
  logic        sel_we;
  logic        sel_err;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_byteen;

  assign arb_req = {m1_req, m0_req};

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_in (rst_in),
    .req    (arb_req),
    .gnt    (arb_gnt)
  );

  always_comb begin
    sel_m1     = arb_gnt[1];
    any_gnt    = |arb_gnt;
    sel_addr   = sel_m1 ? m1_addr   : m0_addr;
    sel_we     = sel_m1 ? m1_we     : m0_we;
    sel_byteen = sel_m1 ? m1_byteen : m0_byteen;
    sel_wdata  = sel_m1 ? m1_wdata  : m0_wdata;
  end

`ifdef MEM_ARB_ADDR_CHECK_EN
  // 33-bit compare so a window ending at 4 GiB does not wrap
  localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + (33'd1 << (RAM_AW + 2));

  assign sel_err = ({1'b0, sel_addr} < {1'b0, RAM_BASE}) ||
                   ({1'b0, sel_addr} >= RAM_END) ||
                   (sel_addr[1:0] != 2'b00);
`else
  logic unused_addr_bits;

  assign sel_err          = 1'b0;
  assign unused_addr_bits = ^{sel_addr[31:RAM_AW+2], sel_addr[1:0], RAM_BASE};
`endif

  assign m0_gnt     = arb_gnt[0];
  assign m1_gnt     = arb_gnt[1];
  assign ram_addr   = sel_addr[RAM_AW+1:2];
  assign ram_byteen = sel_byteen;
  assign ram_wdata  = sel_wdata;
  assign ram_we     = any_gnt && sel_we && !sel_err;

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   wr_q, wr_d;
  logic   err_q, err_d;

  always_comb begin
    state_d = IDLE;
    owner_d = owner_q;
    wr_d    = wr_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE:    state_d = any_gnt ? RESP : IDLE;
      RESP:    state_d = any_gnt ? RESP : IDLE;
      default: state_d = IDLE;
    endcase
    if (any_gnt) begin
      owner_d = sel_m1 ? M1 : M0;
      wr_d    = sel_we;
      err_d   = sel_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= IDLE;
      owner_q <= M0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // A response already due is suppressed in the reset cycle itself
  logic        resp_due;
  logic [31:0] resp_data;

  assign resp_due  = (state_q == RESP) && !rst_in;
  assign resp_data = (wr_q || err_q) ? 32'd0 : ram_rdata;

  assign m0_rvalid = resp_due && (owner_q == M0);
  assign m1_rvalid = resp_due && (owner_q == M1);
  assign m0_err    = m0_rvalid && err_q;
  assign m1_err    = m1_rvalid && err_q;
  assign m0_rdata  = m0_rvalid ? resp_data : 32'd0;
  assign m1_rdata  = m1_rvalid ? resp_data : 32'd0;

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - scoreboard bench for mem_arb with a registered RAM model
module tb_mem_arb;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [31:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]    m0_byteen, m1_byteen;
  logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0]   m0_rdata, m1_rdata;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_byteen;
  logic          ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = 32'd0;

  mem_arb #(.RAM_AW(AW), .RAM_BASE(32'h0002_0000)) dut (
    .clk(clk), .rst_in(rst_in),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_byteen(m0_byteen),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_byteen(m1_byteen),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .ram_addr(ram_addr), .ram_byteen(ram_byteen), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_f(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {17'd0, a};
  endfunction

  always @(posedge clk) ram_rdata <= ram_f(ram_addr);

  typedef struct packed {
    logic r0; logic w0; logic [31:0] a0; logic [3:0] b0; logic [31:0] d0;
    logic r1; logic w1; logic [31:0] a1; logic [3:0] b1; logic [31:0] d1;
    logic [1:0] g;
  } vec_t;

  typedef struct packed {
    logic [2:0]  ctl;
    logic [50:0] fwd;
    logic [67:0] resp;
  } exp_t;

  logic [67:0] obs_resp;
  logic [2:0]  obs_ctl;
  logic [50:0] obs_fwd;
  assign obs_resp = {m0_rvalid, m0_err, m0_rdata, m1_rvalid, m1_err, m1_rdata};
  assign obs_ctl  = {m1_gnt, m0_gnt, ram_we};
  assign obs_fwd  = {ram_addr, ram_byteen, ram_wdata};

  logic [67:0] sb[$];
  int n_vec  = 0;
  int n_fail = 0;

  function automatic logic bad_addr(input logic [31:0] a);
`ifdef MEM_ARB_ADDR_CHECK_EN
    return (a < 32'h0002_0000) || (a >= 32'h0004_0000) || (a[1:0] != 2'b00);
`else
    return (a === 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic vec_t mkv(input logic r0, input logic w0, input logic [31:0] a0,
                               input logic [3:0] b0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [31:0] a1,
                               input logic [3:0] b1, input logic [31:0] d1,
                               input logic [1:0] g);
    return '{r0, w0, a0, b0, d0, r1, w1, a1, b1, d1, g};
  endfunction

  function automatic exp_t model(input vec_t v);
    exp_t        e;
    logic        we, bad;
    logic [31:0] a, d, rd;
    logic [3:0]  b;
    e = '0;
    if (v.g == 2'd2) begin
      we = v.w1; a = v.a1; b = v.b1; d = v.d1;
    end else begin
      we = v.w0; a = v.a0; b = v.b0; d = v.d0;
    end
    bad   = bad_addr(a);
    rd    = (we || bad) ? 32'd0 : ram_f(a[AW+1:2]);
    e.fwd = {a[AW+1:2], b, d};
    case (v.g)
      2'd1: begin e.ctl = {1'b0, 1'b1, we && !bad}; e.resp = {1'b1, bad, rd, 34'd0}; end
      2'd2: begin e.ctl = {1'b1, 1'b0, we && !bad}; e.resp = {34'd0, 1'b1, bad, rd}; end
      default: begin e.ctl = 3'b000; e.resp = '0; end
    endcase
    return e;
  endfunction

  task automatic apply(input vec_t v);
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_byteen = v.b0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_byteen = v.b1; m1_wdata = v.d1;
  endtask

  vec_t idle_v;
  assign idle_v = '0;

  task automatic test_reset();
    rst_in = 1'b1;
    apply(mkv(1, 1, 32'h0002_0000, 4'hF, 32'h1234_5678, 1, 0, 32'h0002_0004, 4'hF, 0, 0));
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if (obs_ctl !== 3'b000) begin
        n_fail++; $display("FAIL reset_ctl got %b want 000", obs_ctl);
      end
      n_vec++;
      if (obs_resp !== 68'd0) begin
        n_fail++; $display("FAIL reset_resp got %h want 0", obs_resp);
      end
      @(posedge clk); #1;
    end
    rst_in = 1'b0;
    apply(idle_v);
    sb.delete();
    sb.push_back(68'd0);
  endtask

  task automatic test_round_robin();
    vec_t tbl[$];
    exp_t e;
    logic [67:0] want;
    tbl.push_back(mkv(1, 0, 32'h0002_0100, 4'hF, 0, 1, 0, 32'h0002_0200, 4'hF, 0, 1));
    tbl.push_back(mkv(1, 0, 32'h0002_0104, 4'hF, 0, 1, 0, 32'h0002_0200, 4'hF, 0, 2));
    tbl.push_back(mkv(1, 0, 32'h0002_0104, 4'hF, 0, 1, 0, 32'h0002_0204, 4'hF, 0, 1));
    tbl.push_back(mkv(1, 0, 32'h0002_0108, 4'hF, 0, 1, 0, 32'h0002_0204, 4'hF, 0, 2));
    tbl.push_back(idle_v);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = model(tbl[i]);
      @(negedge clk);
      want = sb.pop_front();
      n_vec++;
      if (obs_resp !== want) begin n_fail++; $display("FAIL rr_resp[%0d] got %h want %h", i, obs_resp, want); end
      n_vec++;
      if (obs_ctl !== e.ctl) begin n_fail++; $display("FAIL rr_ctl[%0d] got %b want %b", i, obs_ctl, e.ctl); end
      if (tbl[i].g != 2'd0) begin
        n_vec++;
        if (obs_fwd !== e.fwd) begin n_fail++; $display("FAIL rr_fwd[%0d] got %h want %h", i, obs_fwd, e.fwd); end
      end
      sb.push_back(e.resp);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_read();
    vec_t tbl[$];
    exp_t e;
    logic [67:0] want;
    tbl.push_back(mkv(1, 0, 32'h0002_0010, 4'h0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(idle_v);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = model(tbl[i]);
      @(negedge clk);
      want = sb.pop_front();
      n_vec++;
      if (obs_resp !== want) begin n_fail++; $display("FAIL rd_resp[%0d] got %h want %h", i, obs_resp, want); end
      n_vec++;
      if (obs_ctl !== e.ctl) begin n_fail++; $display("FAIL rd_ctl[%0d] got %b want %b", i, obs_ctl, e.ctl); end
      if (tbl[i].g != 2'd0) begin
        n_vec++;
        if (ram_addr !== 15'd4) begin n_fail++; $display("FAIL rd_ram_addr got %0d want 4", ram_addr); end
      end
      sb.push_back(e.resp);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write();
    vec_t tbl[$];
    exp_t e;
    logic [67:0] want;
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, 1, 32'h0002_0040, 4'b0011, 32'hDEAD_BEEF, 2));
    tbl.push_back(idle_v);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = model(tbl[i]);
      @(negedge clk);
      want = sb.pop_front();
      n_vec++;
      if (obs_resp !== want) begin n_fail++; $display("FAIL wr_resp[%0d] got %h want %h", i, obs_resp, want); end
      n_vec++;
      if (obs_ctl !== e.ctl) begin n_fail++; $display("FAIL wr_ctl[%0d] got %b want %b", i, obs_ctl, e.ctl); end
      if (tbl[i].g != 2'd0) begin
        n_vec++;
        if (obs_fwd !== e.fwd) begin n_fail++; $display("FAIL wr_fwd[%0d] got %h want %h", i, obs_fwd, e.fwd); end
      end
      sb.push_back(e.resp);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    vec_t tbl[$];
    exp_t e;
    logic [67:0] want;
    tbl.push_back(mkv(1, 1, 32'h0002_0080, 4'hF, 32'h1111_1111, 1, 0, 32'h0002_00A0, 4'hF, 0, 1));
    tbl.push_back(mkv(1, 0, 32'h0002_0084, 4'b0101, 0, 1, 0, 32'h0002_00A0, 4'hF, 0, 2));
    tbl.push_back(mkv(1, 0, 32'h0002_0084, 4'b0101, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(1, 1, 32'h0002_0088, 4'b1100, 32'h2222_3333, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(1, 0, 32'h0002_008C, 4'hF, 0, 1, 1, 32'h0002_00A4, 4'b0110, 32'h4444_5555, 2));
    tbl.push_back(mkv(1, 0, 32'h0002_008C, 4'hF, 0, 1, 1, 32'h0002_00A8, 4'hF, 32'h6666_7777, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, 1, 32'h0002_00A8, 4'hF, 32'h6666_7777, 2));
    tbl.push_back(mkv(1, 0, 32'h0002_0090, 4'hF, 0, 1, 0, 32'h0002_00AC, 4'hF, 0, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, 0, 32'h0002_00AC, 4'hF, 0, 2));
    tbl.push_back(idle_v);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = model(tbl[i]);
      @(negedge clk);
      want = sb.pop_front();
      n_vec++;
      if (obs_resp !== want) begin n_fail++; $display("FAIL b2b_resp[%0d] got %h want %h", i, obs_resp, want); end
      n_vec++;
      if (obs_ctl !== e.ctl) begin n_fail++; $display("FAIL b2b_ctl[%0d] got %b want %b", i, obs_ctl, e.ctl); end
      if (tbl[i].g != 2'd0) begin
        n_vec++;
        if (obs_fwd !== e.fwd) begin n_fail++; $display("FAIL b2b_fwd[%0d] got %h want %h", i, obs_fwd, e.fwd); end
      end
      sb.push_back(e.resp);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addr_check();
    vec_t tbl[$];
    exp_t e;
    logic [67:0] want;
    tbl.push_back(mkv(1, 0, 32'h0000_0100, 4'hF, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, 1, 32'h0003_FFFC, 4'hF, 32'hA5A5_0001, 2));
    tbl.push_back(mkv(1, 1, 32'h0004_0000, 4'hF, 32'hA5A5_0002, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, 0, 32'h0002_0002, 4'b0101, 0, 2));
    tbl.push_back(mkv(1, 1, 32'h0002_0000, 4'b1000, 32'hA5A5_0003, 0, 0, 0, 0, 0, 1));
    tbl.push_back(idle_v);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = model(tbl[i]);
      @(negedge clk);
      want = sb.pop_front();
      n_vec++;
      if (obs_resp !== want) begin n_fail++; $display("FAIL ac_resp[%0d] got %h want %h", i, obs_resp, want); end
      n_vec++;
      if (obs_ctl !== e.ctl) begin n_fail++; $display("FAIL ac_ctl[%0d] got %b want %b", i, obs_ctl, e.ctl); end
      if (tbl[i].g != 2'd0) begin
        n_vec++;
        if (obs_fwd !== e.fwd) begin n_fail++; $display("FAIL ac_fwd[%0d] got %h want %h", i, obs_fwd, e.fwd); end
      end
      sb.push_back(e.resp);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    vec_t v;
    exp_t e;
    logic [67:0] want;
    v = mkv(1, 0, 32'h0002_0020, 4'hF, 0, 0, 0, 0, 0, 0, 1);
    apply(v);
    e = model(v);
    @(negedge clk);
    want = sb.pop_front();
    n_vec++;
    if (obs_resp !== want) begin n_fail++; $display("FAIL rm_pre_resp got %h want %h", obs_resp, want); end
    n_vec++;
    if (obs_ctl !== e.ctl) begin n_fail++; $display("FAIL rm_pre_ctl got %b want %b", obs_ctl, e.ctl); end
    @(posedge clk); #1;
    // reset lands in the cycle the m0 response would have been returned
    rst_in = 1'b1;
    v = mkv(1, 0, 32'h0002_0030, 4'hF, 0, 1, 0, 32'h0002_0040, 4'hF, 0, 0);
    apply(v);
    @(negedge clk);
    void'(sb.pop_front());
    n_vec++;
    if (obs_resp !== 68'd0) begin n_fail++; $display("FAIL rm_rst_resp got %h want 0", obs_resp); end
    n_vec++;
    if (obs_ctl !== 3'b000) begin n_fail++; $display("FAIL rm_rst_ctl got %b want 000", obs_ctl); end
    @(posedge clk); #1;
    rst_in = 1'b0;
    v.g = 2'd1;
    e = model(v);
    @(negedge clk);
    n_vec++;
    if (obs_resp !== 68'd0) begin n_fail++; $display("FAIL rm_post_resp got %h want 0", obs_resp); end
    n_vec++;
    if (obs_ctl !== 3'b010) begin n_fail++; $display("FAIL rm_post_ctl got %b want 010", obs_ctl); end
    @(posedge clk); #1;
    apply(idle_v);
    @(negedge clk);
    n_vec++;
    if (obs_resp !== e.resp) begin n_fail++; $display("FAIL rm_post_rsp2 got %h want %h", obs_resp, e.resp); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_in = 1'b1;
    apply(idle_v);
    test_reset();
    test_round_robin();
    test_single_read();
    test_write();
    test_back_to_back();
    test_addr_check();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter RAM_AW, default 15, meaning RAM word-address width.
REQ-002 SHALL have parameter RAM_BASE, default 32'h0002_0000, meaning byte base address of the RAM window (2^(RAM_AW+2) bytes).
REQ-003 SHALL have ports:
  clk        in   1       system clock; one clock, all logic on rising edge
  rst_in     in   1       synchronous reset, active-high
  m0_req     in   1       master 0 (core data port) request
  m0_we      in   1       m0 write enable
  m0_addr    in   32      m0 byte address
  m0_byteen  in   4       m0 byte enables
  m0_wdata   in   32      m0 write data
  m0_gnt     out  1       m0 request accepted this cycle
  m0_rvalid  out  1       m0 response valid
  m0_rdata   out  32      m0 read data
  m0_err     out  1       m0 response is an error
  m1_*       same set as m0_*, for master 1 (debug/DMA port)
  ram_addr   out  RAM_AW  RAM word address
  ram_byteen out  4       RAM byte enables
  ram_we     out  1       RAM write enable
  ram_wdata  out  32      RAM write data
  ram_rdata  in   32      RAM registered output, valid 1 cycle after address

Function
REQ-004 SHALL share the single synchronous RAM port between m0 and m1, one access per cycle.
REQ-005 SHALL grant combinationally in the cycle a request is present; mX_gnt high for exactly one cycle per accepted request.
REQ-006 SHALL arbitrate round-robin: with both requesting, grant the master not granted last; after reset m0 has priority.
REQ-007 SHALL keep a requester's address/data valid by the master while mX_req high and mX_gnt low (master holds; arbiter does not latch unaccepted requests).
REQ-008 SHALL drive ram_addr = granted addr[RAM_AW+1:2], ram_byteen/ram_wdata from granted master, ram_we = granted we AND gnt; ram_we SHALL be 0 in any cycle without a grant.
REQ-009 SHALL return the response exactly 1 cycle after gnt: mX_rvalid high 1 cycle to the owning master only; reads return ram_rdata, writes return rdata 0.
REQ-010 SHALL track the owner in a registered state machine: IDLE (no response due) and RESP (response due to stored owner); IDLE->RESP on any grant, RESP->RESP on grant in same cycle, RESP->IDLE otherwise.
REQ-011 SHALL support back-to-back grants every cycle (full throughput), including alternating owners.
REQ-012 SHALL drive mX_rdata = 0 when mX_rvalid low.
REQ-013 SHALL ignore mX_byteen on reads (ram_byteen still driven).

Reset
REQ-014 SHALL, while rst_in high at a clock edge, force state IDLE, last-grant pointer to m1 (so m0 wins next), and hold all mX_gnt, mX_rvalid, mX_err, ram_we low.
REQ-015 SHALL drop any response in flight when reset asserts mid-transaction; no rvalid after reset release for pre-reset grants.

Configuration
REQ-016 SHALL use macro MEM_ARB_ADDR_CHECK_EN: when defined, a request with addr outside [RAM_BASE, RAM_BASE+2^(RAM_AW+2)) or addr[1:0] != 0 SHALL be granted, not forwarded (ram_we 0), and answered next cycle with rvalid=1, err=1, rdata=0.
REQ-017 SHALL, without MEM_ARB_ADDR_CHECK_EN, forward all requests using low address bits only and tie mX_err to 0.

Structure
REQ-018 SHALL place state enum (IDLE, RESP), owner typedef (M0, M1) and RAM_BASE default in package mem_arb_pkg.
REQ-019 SHALL implement the round-robin decision in sub-module rr_arb2 (2 requests in, 2 one-hot grants out, registered last-grant pointer).

Verification
REQ-020 SHALL cover: m0 read addr 0x0002_0010 alone -> m0_gnt same cycle, ram_addr=4, m0_rvalid next cycle with ram_rdata.
REQ-021 SHALL cover: m0 and m1 request continuously for 4 cycles after reset -> grants m0,m1,m0,m1; each rvalid 1 cycle later to correct master.
REQ-022 SHALL cover: m1 write 0xDEADBEEF byteen 4'b0011 -> ram_we=1 one cycle, ram_byteen=0011, m1_rvalid next cycle, m1_rdata=0.
REQ-023 SHALL cover: with MEM_ARB_ADDR_CHECK_EN, m0 read 0x0000_0100 -> ram_we 0, m0_rvalid=1 and m0_err=1 next cycle; without macro, m0_err=0.
REQ-024 SHALL cover: rst_in asserted the cycle after m0_gnt -> no m0_rvalid; after release, m0 wins a simultaneous request.
